// File: rtl/fib_seq_engine.sv
// Fibonacci sequence engine: on start, walks F(0)..F(n) and writes either the
// final term (single mode) or every term (stream mode) to a linear address range.
module fib_seq_engine #(
    parameter int unsigned           WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  mode_i,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  write_en_o,
    output logic [WIDTH-1:0]      data_o,
    output logic                  overflow_o,
    output logic                  done_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]            state_r;
    logic [WIDTH-1:0]      n_r;
    logic                  mode_r;
    logic [WIDTH-1:0]      i_r;
    logic [WIDTH-1:0]      a_r;
    logic [WIDTH-1:0]      b_r;
    logic                  fa_r;
    logic                  fb_r;

    logic                  busy_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  write_en_r;
    logic [WIDTH-1:0]      data_r;
    logic                  overflow_r;
    logic                  done_r;

    logic [WIDTH:0]        sum_s;
    logic                  last_s;
    logic                  write_s;
    logic [ADDR_WIDTH-1:0] addr_next_s;
    logic                  fb_next_s;

    // Next-term arithmetic, termination test and write address for the current index
    always_comb begin
        sum_s       = {1'b0, a_r} + {1'b0, b_r};
        last_s      = 1'b0;
        write_s     = 1'b0;
        addr_next_s = BASE_ADDR;
        // Overflow is sticky: once a term has wrapped, all later terms are wrong too
        fb_next_s   = sum_s[WIDTH] | fa_r | fb_r;
        // Termination is decided before i increments, so n = 2^WIDTH-1 still ends
        if (i_r == n_r) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
        if (mode_r || last_s) begin
            write_s = 1'b1;
        end else begin
            write_s = 1'b0;
        end
        if (mode_r) begin
            addr_next_s = BASE_ADDR + ADDR_WIDTH'(i_r);
        end else begin
            addr_next_s = BASE_ADDR;
        end
    end

    // Control FSM, sequence state and registered write-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            n_r        <= ZERO_W;
            mode_r     <= 1'b0;
            i_r        <= ZERO_W;
            a_r        <= ZERO_W;
            b_r        <= ZERO_W;
            fa_r       <= 1'b0;
            fb_r       <= 1'b0;
            busy_r     <= 1'b0;
            addr_r     <= BASE_ADDR;
            write_en_r <= 1'b0;
            data_r     <= ZERO_W;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    write_en_r <= 1'b0;
                    done_r     <= 1'b0;
                    if (start_i) begin
                        n_r     <= data_i;
                        mode_r  <= mode_i;
                        i_r     <= ZERO_W;
                        a_r     <= ZERO_W;
                        b_r     <= ONE_W;
                        fa_r    <= 1'b0;
                        fb_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (write_s) begin
                        write_en_r <= 1'b1;
                        addr_r     <= addr_next_s;
                        data_r     <= a_r;
                        overflow_r <= fa_r;
                    end else begin
                        write_en_r <= 1'b0;
                    end
                    if (last_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        a_r     <= b_r;
                        b_r     <= sum_s[WIDTH-1:0];
                        fa_r    <= fb_r;
                        fb_r    <= fb_next_s;
                        i_r     <= i_r + ONE_W;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    write_en_r <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_r;
    assign addr_o     = addr_r;
    assign write_en_o = write_en_r;
    assign data_o     = data_r;
    assign overflow_o = overflow_r;
    assign done_o     = done_r;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for fib_seq_engine: two configurations checked every cycle against a
// cycle-indexed schedule of expected writes built from plain Fibonacci arithmetic.
module tb_fib_seq_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: WIDTH 32, ADDR_WIDTH 32, BASE 0x100 ; dut1: WIDTH 8, ADDR_WIDTH 4, BASE 14
    logic        r0 = 1'b1, s0 = 1'b0, m0 = 1'b0;
    logic [31:0] d0 = 32'd0;
    logic        bu0, we0, ov0, dn0;
    logic [31:0] ad0, do0;

    logic        r1 = 1'b1, s1 = 1'b0, m1 = 1'b0;
    logic [7:0]  d1 = 8'd0;
    logic        bu1, we1, ov1, dn1;
    logic [3:0]  ad1;
    logic [7:0]  do1;

    fib_seq_engine #(.WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h100)) dut0 (
        .clk(clk), .rst(r0), .start_i(s0), .data_i(d0), .mode_i(m0),
        .busy_o(bu0), .addr_o(ad0), .write_en_o(we0), .data_o(do0),
        .overflow_o(ov0), .done_o(dn0)
    );

    fib_seq_engine #(.WIDTH(8), .ADDR_WIDTH(4), .BASE_ADDR(4'd14)) dut1 (
        .clk(clk), .rst(r1), .start_i(s1), .data_i(d1), .mode_i(m1),
        .busy_o(bu1), .addr_o(ad1), .write_en_o(we1), .data_o(do1),
        .overflow_o(ov1), .done_o(dn1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input int d, input longint unsigned act,
                         input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int wdt(int d);  return (d == 0) ? 32 : 8; endfunction
    function automatic int awdt(int d); return (d == 0) ? 32 : 4; endfunction
    function automatic longint unsigned base(int d); return (d == 0) ? 64'h100 : 64'd14; endfunction
    function automatic longint unsigned mask(int w); return (64'd1 << w) - 64'd1; endfunction
    function automatic int key(int c, int d); return c * 2 + d; endfunction

    function automatic longint unsigned fib(int n);
        longint unsigned x = 64'd0, y = 64'd1, t;
        for (int j = 0; j < n; j++) begin
            t = x + y; x = y; y = t;
        end
        return x;
    endfunction

    bit              exp_we[int], exp_done[int], exp_busy[int], exp_rst[int], exp_ovf[int];
    longint unsigned exp_addr[int], exp_data[int];

    // A start sampled at edge k produces term i in cycle k+1+i; busy covers cycles k..k+n
    function automatic void model_start(int d, int k, int n, bit m);
        longint unsigned v;
        int c;
        if (exp_busy.exists(key(k - 1, d))) return;
        for (int c2 = k; c2 <= k + n; c2++) exp_busy[key(c2, d)] = 1'b1;
        for (int i = 0; i <= n; i++) begin
            if (m || i == n) begin
                c = key(k + 1 + i, d);
                v = fib(i);
                exp_we[c]   = 1'b1;
                exp_data[c] = v & mask(wdt(d));
                exp_ovf[c]  = ((v >> wdt(d)) != 64'd0);
                exp_addr[c] = m ? ((base(d) + longint'(i)) & mask(awdt(d))) : base(d);
            end
        end
        exp_done[key(k + 1 + n, d)] = 1'b1;
    endfunction

    function automatic void model_rst(int d, int k);
        exp_rst[key(k, d)] = 1'b1;
        for (int c = k; c < k + 200; c++) begin
            if (exp_we.exists(key(c, d)))   exp_we.delete(key(c, d));
            if (exp_done.exists(key(c, d))) exp_done.delete(key(c, d));
            if (exp_busy.exists(key(c, d))) exp_busy.delete(key(c, d));
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    bit              live[2];
    longint unsigned h_addr[2], h_data[2];
    bit              h_ovf[2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (exp_rst.exists(key(cyc, d))) begin
                live[d] = 1'b1; h_addr[d] = base(d); h_data[d] = 64'd0; h_ovf[d] = 1'b0;
            end
            if (exp_we.exists(key(cyc, d))) begin
                h_addr[d] = exp_addr[key(cyc, d)];
                h_data[d] = exp_data[key(cyc, d)];
                h_ovf[d]  = exp_ovf[key(cyc, d)];
            end
            if (live[d]) begin
                check("write_en", d, (d == 0) ? we0 : we1, exp_we.exists(key(cyc, d)));
                check("done",     d, (d == 0) ? dn0 : dn1, exp_done.exists(key(cyc, d)));
                check("busy",     d, (d == 0) ? bu0 : bu1, exp_busy.exists(key(cyc, d)));
                check("addr",     d, (d == 0) ? longint'(ad0) : longint'(ad1), h_addr[d]);
                check("data",     d, (d == 0) ? longint'(do0) : longint'(do1), h_data[d]);
                check("overflow", d, (d == 0) ? ov0 : ov1, h_ovf[d]);
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic issue(input int d, input int n, input bit m);
        model_start(d, cyc + 1, n, m);
        if (d == 0) begin s0 = 1'b1; d0 = n; m0 = m; end
        else        begin s1 = 1'b1; d1 = n[7:0]; m1 = m; end
        @(posedge clk); @(negedge clk);
        s0 = 1'b0; s1 = 1'b0;
        d0 = $urandom; d1 = 8'($urandom); m0 = 1'($urandom); m1 = 1'($urandom);
    endtask

    task automatic pulse_rst(input int d);
        model_rst(d, cyc + 1);
        if (d == 0) r0 = 1'b1; else r1 = 1'b1;
        @(posedge clk); @(negedge clk);
        r0 = 1'b0; r1 = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget, output int waited);
        bit ok = 1'b0;
        waited = 0;
        while (!ok && waited < budget) begin
            @(negedge clk);
            waited++;
            ok = (d == 0) ? dn0 : dn1;
        end
        if (!ok) check("done_timeout", d, 0, 1);
    endtask

    int lit[7] = '{0, 1, 1, 2, 3, 5, 8};
    int w;
    int unsigned rn;

    initial begin
        model_rst(0, 1);
        model_rst(1, 1);
        @(negedge clk);
        r0 = 1'b0; r1 = 1'b0;
        @(negedge clk);

        // single mode n=0..6: value, latency n+1, fixed address
        for (int n = 0; n < 7; n++) begin
            issue(0, n, 1'b0);
            wait_done(0, 40, w);
            check("single_latency", 0, w, n + 1);
            check("single_value",   0, do0, lit[n]);
            check("single_addr",    0, ad0, 32'h100);
        end

        // stream n=6
        issue(0, 6, 1'b1);
        wait_done(0, 40, w);
        check("stream_last_addr", 0, ad0, 32'h106);
        check("stream_last_data", 0, do0, 8);

        // 8-bit overflow boundary
        issue(1, 13, 1'b0);
        wait_done(1, 40, w);
        check("w8_f13", 1, do1, 233);
        check("w8_f13_ovf", 1, ov1, 0);
        issue(1, 14, 1'b0);
        wait_done(1, 40, w);
        check("w8_f14", 1, do1, 121);
        check("w8_f14_ovf", 1, ov1, 1);
        issue(1, 15, 1'b1);
        wait_done(1, 40, w);
        issue(1, 3, 1'b1);
        wait_done(1, 40, w);
        check("addr_wrap_last", 1, ad1, 1);

        // start while busy is ignored; start in done cycle accepted back-to-back
        issue(0, 10, 1'b0);
        repeat (4) @(negedge clk);
        issue(0, 3, 1'b0);
        wait_done(0, 40, w);
        check("ignored_start_result", 0, do0, 55);
        issue(0, 3, 1'b0);
        wait_done(0, 40, w);
        check("b2b_latency", 0, w, 4);
        check("b2b_value",   0, do0, 2);

        // reset mid-run aborts, then a fresh run works
        issue(0, 20, 1'b1);
        repeat (4) @(negedge clk);
        pulse_rst(0);
        check("abort_busy", 0, bu0, 0);
        issue(0, 5, 1'b0);
        wait_done(0, 40, w);
        check("after_abort", 0, do0, 5);

        // randomized traffic, including starts while busy and occasional resets
        for (int it = 0; it < 60; it++) begin
            int d;
            d  = int'($urandom_range(0, 1));
            rn = $urandom_range(0, 9);
            if (rn == 0) pulse_rst(d);
            else issue(d, int'($urandom_range(0, (d == 0) ? 60 : 20)), 1'($urandom));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        repeat (80) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
